// File: rtl/com_filter_pkg.sv
// ---------------------------------------------------------------------------
// com_filter_pkg
// Shared defaults and the elaboration-time parameter check for the
// multi-channel debounce/glitch filter (com_filter_ch, com_filter_multi).
// ---------------------------------------------------------------------------
package com_filter_pkg;

    localparam int DEF_CNT_W       = 10;
    localparam int DEF_RISE_CNT    = 10;
    localparam int DEF_FALL_CNT    = 10;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_GLITCH_W    = 8;
    localparam int DEF_GLITCH_LIM  = 16;

    // Thresholds must be non-zero and representable in the run counter,
    // the synchroniser needs at least two flops, and the glitch limit must
    // be reachable by the glitch counter.
    function automatic bit params_ok(input int cnt_w, input int rise, input int fall,
                                     input int sync, input int glitch_w, input int glitch_lim);
        longint max_cnt;
        longint max_glitch;
        max_cnt    = (longint'(1) << cnt_w) - 1;
        max_glitch = (longint'(1) << glitch_w) - 1;
        return (cnt_w >= 1) && (rise >= 1) && (fall >= 1) &&
               (longint'(rise) <= max_cnt) && (longint'(fall) <= max_cnt) &&
               (sync >= 2) && (glitch_w >= 1) && (glitch_lim >= 1) &&
               (longint'(glitch_lim) <= max_glitch);
    endfunction

endpackage

// File: rtl/com_filter_ch.sv
// ---------------------------------------------------------------------------
// com_filter_ch
// One debounce channel: synchroniser, run counter, filtered level with
// rise/fall edge pulses, and an optional chatter (glitch) detector.
// Optional feature macro: COM_FILTER_CHATTER_EN (glitch counter + flag).
//
// Ports:
//   CLK_50M      in   system clock
//   Rst_n        in   synchronous active-low reset
//   din          in   raw asynchronous input
//   dout         out  filtered level
//   rise_pls     out  one-cycle pulse, first cycle of dout=1
//   fall_pls     out  one-cycle pulse, first cycle of dout=0
//   glitch_clr   in   clears glitch count and flag
//   glitch_flag  out  sticky chatter flag (0 when feature disabled)
// ---------------------------------------------------------------------------
module com_filter_ch
    import com_filter_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   CNT_W       = DEF_CNT_W,
    parameter int   RISE_CNT    = DEF_RISE_CNT,
    parameter int   FALL_CNT    = DEF_FALL_CNT,
    parameter logic INIT_LVL    = 1'b0,
    parameter int   GLITCH_W    = DEF_GLITCH_W,
    parameter int   GLITCH_LIM  = DEF_GLITCH_LIM
) (
    input  logic CLK_50M,
    input  logic Rst_n,
    input  logic din,
    output logic dout,
    output logic rise_pls,
    output logic fall_pls,
    input  logic glitch_clr,
    output logic glitch_flag
);

    generate
        if (!params_ok(CNT_W, RISE_CNT, FALL_CNT, SYNC_STAGES, GLITCH_W, GLITCH_LIM)) begin : g_bad_params
            $error("com_filter_ch: illegal parameter combination");
        end
    endgenerate

    localparam logic [CNT_W-1:0] RISE_M1 = CNT_W'(RISE_CNT - 1);
    localparam logic [CNT_W-1:0] FALL_M1 = CNT_W'(FALL_CNT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_dout;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic [CNT_W-1:0]       w_thr_m1;

    assign w_s      = r_sync[SYNC_STAGES-1];
    // Threshold depends on the level we would be leaving.
    assign w_thr_m1 = r_dout ? FALL_M1 : RISE_M1;

    always_ff @(posedge CLK_50M) begin
        if (!Rst_n) begin
            r_sync <= {SYNC_STAGES{INIT_LVL}};
            r_dout <= INIT_LVL;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_s == r_dout) begin
                r_cnt <= '0;
            end else if (r_cnt == w_thr_m1) begin
                // Run complete: output and pulse land on the same edge.
                r_dout <= w_s;
                r_cnt  <= '0;
                r_rise <= w_s;
                r_fall <= ~w_s;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dout     = r_dout;
    assign rise_pls = r_rise;
    assign fall_pls = r_fall;

`ifdef COM_FILTER_CHATTER_EN
    localparam logic [GLITCH_W-1:0] G_MAX = '1;
    localparam logic [GLITCH_W-1:0] G_LIM = GLITCH_W'(GLITCH_LIM);

    logic [GLITCH_W-1:0] r_gcnt;
    logic                r_gflag;
    logic                w_discard;
    logic [GLITCH_W-1:0] w_gcnt_inc;

    // A run in progress that sees the input fall back is a rejected glitch.
    assign w_discard  = (w_s == r_dout) && (r_cnt != '0);
    assign w_gcnt_inc = r_gcnt + 1'b1;

    always_ff @(posedge CLK_50M) begin
        if (!Rst_n || glitch_clr) begin
            r_gcnt  <= '0;
            r_gflag <= 1'b0;
        end else if (w_discard && (r_gcnt != G_MAX)) begin
            r_gcnt <= w_gcnt_inc;
            if (w_gcnt_inc >= G_LIM) begin
                r_gflag <= 1'b1;
            end
        end
    end

    assign glitch_flag = r_gflag;
`else
    logic w_unused_glitch_clr;
    assign w_unused_glitch_clr = glitch_clr;
    assign glitch_flag         = 1'b0;
`endif

endmodule

// File: rtl/com_filter_multi.sv
// ---------------------------------------------------------------------------
// com_filter_multi
// CH independent debounce/glitch filter channels for slow control and
// status inputs. Pure structural wrapper around com_filter_ch.
// Optional feature macro: COM_FILTER_CHATTER_EN (per-channel chatter flag).
//
// Ports (all CH bits wide except clock/reset):
//   CLK_50M      in   system clock
//   Rst_n        in   synchronous active-low reset
//   din          in   raw asynchronous inputs
//   dout         out  filtered levels
//   rise_pls     out  dout 0->1 pulses
//   fall_pls     out  dout 1->0 pulses
//   glitch_clr   in   per-channel glitch count/flag clear
//   glitch_flag  out  per-channel sticky chatter flag
// ---------------------------------------------------------------------------
module com_filter_multi
    import com_filter_pkg::*;
#(
    parameter int            CH          = 4,
    parameter int            SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int            CNT_W       = DEF_CNT_W,
    parameter int            RISE_CNT    = DEF_RISE_CNT,
    parameter int            FALL_CNT    = DEF_FALL_CNT,
    parameter logic [CH-1:0] INIT_LVL    = {CH{1'b0}},
    parameter int            GLITCH_W    = DEF_GLITCH_W,
    parameter int            GLITCH_LIM  = DEF_GLITCH_LIM
) (
    input  logic          CLK_50M,
    input  logic          Rst_n,
    input  logic [CH-1:0] din,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] rise_pls,
    output logic [CH-1:0] fall_pls,
    input  logic [CH-1:0] glitch_clr,
    output logic [CH-1:0] glitch_flag
);

    generate
        for (genvar g = 0; g < CH; g++) begin : g_ch
            com_filter_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .CNT_W       (CNT_W),
                .RISE_CNT    (RISE_CNT),
                .FALL_CNT    (FALL_CNT),
                .INIT_LVL    (INIT_LVL[g]),
                .GLITCH_W    (GLITCH_W),
                .GLITCH_LIM  (GLITCH_LIM)
            ) u_ch (
                .CLK_50M     (CLK_50M),
                .Rst_n       (Rst_n),
                .din         (din[g]),
                .dout        (dout[g]),
                .rise_pls    (rise_pls[g]),
                .fall_pls    (fall_pls[g]),
                .glitch_clr  (glitch_clr[g]),
                .glitch_flag (glitch_flag[g])
            );
        end
    endgenerate

endmodule
